regfile_wb_sched: RTL and testbench

Write-back scheduler for the 32-entry, single-write-port register file. It keeps a per-register busy scoreboard so decode can stall on RAW/WAW hazards. It arbitrates the ALU and LSU write-back requesters onto the one write port (`we3`/`a3`/`wd3`). It sits between issue/execute and the register file and is the only block that drives the register file write port.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/wb_arb2.sv | 50 +++++
 rtl/regfile_wb_sched.sv | 99 +++++++++
 tb/tb_regfile_wb_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-back scheduler.
//   XLen      : data width
//   NReg      : number of architectural registers
//   NRegWidth : register address width
//   wb_src_e  : write-back requester identity (ALU / LSU)
//   wb_req_t  : write-back payload (destination + data)
package regfile_pkg;

   localparam int unsigned XLen      = 32;
   localparam int unsigned NReg      = 32;
   localparam int unsigned NRegWidth = $clog2(NReg);

   typedef enum logic [0:0] {
      WbSrcAlu = 1'b0,
      WbSrcLsu = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [NRegWidth-1:0] rd;
      logic [XLen-1:0]      wd;
   } wb_req_t;

endpackage

// File: rtl/wb_arb2.sv
// Two-input write-back arbiter (ALU vs LSU), at most one grant per cycle.
// Build option REGFILE_WB_RR_EN:
//   defined   : round-robin; pointer flips after every contested grant
//   undefined : fixed priority, LSU wins (purely combinational, no clock)
// Ports:
//   clk_i, rst_ni            : clock / sync active-low reset (RR build only)
//   alu_valid_i, lsu_valid_i : requests
//   alu_gnt_o, lsu_gnt_o     : grants (combinational)
module wb_arb2
   import regfile_pkg::*;
(
`ifdef REGFILE_WB_RR_EN
   input  logic clk_i,
   input  logic rst_ni,
`endif
   input  logic alu_valid_i,
   input  logic lsu_valid_i,
   output logic alu_gnt_o,
   output logic lsu_gnt_o
);

`ifdef REGFILE_WB_RR_EN
   wb_src_e ptr_q, ptr_d;

   // Pointer register: names the requester that wins the next contest.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) ptr_q <= WbSrcAlu;
      else         ptr_q <= ptr_d;
   end

   // Uncontested grants leave the pointer alone.
   always_comb begin
      ptr_d = ptr_q;
      if (alu_valid_i && lsu_valid_i) begin
         ptr_d = (ptr_q == WbSrcAlu) ? WbSrcLsu : WbSrcAlu;
      end
   end

   always_comb begin
      alu_gnt_o = alu_valid_i && !(lsu_valid_i && (ptr_q == WbSrcLsu));
      lsu_gnt_o = lsu_valid_i && !(alu_valid_i && (ptr_q == WbSrcAlu));
   end
`else
   always_comb begin
      lsu_gnt_o = lsu_valid_i;
      alu_gnt_o = alu_valid_i && !lsu_valid_i;
   end
`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the single-write-port register file.
// Keeps a per-register busy scoreboard for decode hazard stalls and
// arbitrates ALU/LSU write-backs onto the registered write port.
// Build option REGFILE_WB_RR_EN selects round-robin arbitration
// (default: LSU has fixed priority).
// Ports:
//   clk_i, rst_ni                   : clock, synchronous active-low reset
//   iss_valid_i/iss_rd_i/iss_ready_o: destination reservation at issue
//   rs1_i/rs2_i -> rs1/rs2_busy_o   : scoreboard lookups (combinational)
//   alu_*/lsu_*                     : write-back valid/ready, rd, data
//   we3_o/a3_o/wd3_o                : register file write port (registered)
//   sb_err_o                        : sticky write-back-to-unreserved flag
module regfile_wb_sched #(
   parameter  int unsigned XLen      = regfile_pkg::XLen,
   parameter  int unsigned NReg      = regfile_pkg::NReg,
   localparam int unsigned NRegWidth = $clog2(NReg)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 iss_valid_i,
   input  logic [NRegWidth-1:0] iss_rd_i,
   output logic                 iss_ready_o,
   input  logic [NRegWidth-1:0] rs1_i,
   input  logic [NRegWidth-1:0] rs2_i,
   output logic                 rs1_busy_o,
   output logic                 rs2_busy_o,
   input  logic                 alu_valid_i,
   output logic                 alu_ready_o,
   input  logic [NRegWidth-1:0] alu_rd_i,
   input  logic [XLen-1:0]      alu_wd_i,
   input  logic                 lsu_valid_i,
   output logic                 lsu_ready_o,
   input  logic [NRegWidth-1:0] lsu_rd_i,
   input  logic [XLen-1:0]      lsu_wd_i,
   output logic                 we3_o,
   output logic [NRegWidth-1:0] a3_o,
   output logic [XLen-1:0]      wd3_o,
   output logic                 sb_err_o
);
   import regfile_pkg::*;

   logic [NReg-1:0] busy_q, busy_d;
   logic            alu_gnt, lsu_gnt, gnt_any, wb_err;
   wb_req_t         alu_req, lsu_req, gnt_req;
   wb_src_e         gnt_src;

   wb_arb2 u_arb (
`ifdef REGFILE_WB_RR_EN
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
`endif
      .alu_valid_i (alu_valid_i),
      .lsu_valid_i (lsu_valid_i),
      .alu_gnt_o   (alu_gnt),
      .lsu_gnt_o   (lsu_gnt)
   );

   // Handshakes, granted request mux and scoreboard lookups.
   always_comb begin
      alu_req     = '{rd: alu_rd_i, wd: alu_wd_i};
      lsu_req     = '{rd: lsu_rd_i, wd: lsu_wd_i};
      gnt_src     = lsu_gnt ? WbSrcLsu : WbSrcAlu;
      gnt_req     = (gnt_src == WbSrcLsu) ? lsu_req : alu_req;
      gnt_any     = rst_ni && (alu_gnt || lsu_gnt);
      alu_ready_o = rst_ni && alu_gnt;
      lsu_ready_o = rst_ni && lsu_gnt;
      iss_ready_o = rst_ni && iss_valid_i && !busy_q[iss_rd_i];
      rs1_busy_o  = busy_q[rs1_i];
      rs2_busy_o  = busy_q[rs2_i];
      wb_err      = gnt_any && (gnt_req.rd != '0) && !busy_q[gnt_req.rd];
   end

   // Clear on the cycle the register file captures, set on accepted issue.
   // Both cannot hit the same register: issue to a busy rd is stalled.
   always_comb begin
      busy_d = busy_q;
      if (we3_o) busy_d[a3_o] = 1'b0;
      if (iss_ready_o && (iss_rd_i != '0)) busy_d[iss_rd_i] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         busy_q   <= '0;
         we3_o    <= 1'b0;
         a3_o     <= '0;
         wd3_o    <= '0;
         sb_err_o <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         we3_o    <= gnt_any && (gnt_req.rd != '0);
         sb_err_o <= sb_err_o || wb_err;
         if (gnt_any) begin
            a3_o  <= gnt_req.rd;
            wd3_o <= gnt_req.wd;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed test-plan scenarios followed by
// random traffic, all checked against a behavioural scoreboard model.
module tb_regfile_wb_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iss_v, iss_rdy;
   logic [4:0]  iss_rd, rs1, rs2;
   logic        rs1_b, rs2_b;
   logic        alu_v, alu_rdy, lsu_v, lsu_rdy;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_wd, lsu_wd;
   logic        we3, sb_err;
   logic [4:0]  a3;
   logic [31:0] wd3;

   always #5 clk = ~clk;

   regfile_wb_sched dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .iss_valid_i (iss_v),
      .iss_rd_i    (iss_rd),
      .iss_ready_o (iss_rdy),
      .rs1_i       (rs1),
      .rs2_i       (rs2),
      .rs1_busy_o  (rs1_b),
      .rs2_busy_o  (rs2_b),
      .alu_valid_i (alu_v),
      .alu_ready_o (alu_rdy),
      .alu_rd_i    (alu_rd),
      .alu_wd_i    (alu_wd),
      .lsu_valid_i (lsu_v),
      .lsu_ready_o (lsu_rdy),
      .lsu_rd_i    (lsu_rd),
      .lsu_wd_i    (lsu_wd),
      .we3_o       (we3),
      .a3_o        (a3),
      .wd3_o       (wd3),
      .sb_err_o    (sb_err)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: reserved-register set, the pending register-file write,
   // the sticky error and which requester wins the next contest.
   bit          busy_m [32];
   bit          we_m   = 1'b0;
   bit          err_m  = 1'b0;
   bit          lsu_next_m = 1'b0;
   logic [4:0]  a_m    = '0;
   logic [31:0] wd_m   = '0;
   bit          ag, lg;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: check every output mid-cycle against the model, advance the
   // model, and return #1 after the rising edge.
   task automatic step();
      bit          acc, both;
      logic [4:0]  grd;
      logic [31:0] gwd;
      @(negedge clk);
      ag   = 1'b0;
      lg   = 1'b0;
      both = alu_v && lsu_v;
      if (rst_n) begin
         if (both) begin
`ifdef REGFILE_WB_RR_EN
            if (lsu_next_m) lg = 1'b1; else ag = 1'b1;
`else
            lg = 1'b1;
`endif
         end else begin
            ag = alu_v;
            lg = lsu_v;
         end
      end
      acc = rst_n && iss_v && !busy_m[iss_rd];
      chk("iss_ready", iss_rdy, acc);
      chk("alu_ready", alu_rdy, ag);
      chk("lsu_ready", lsu_rdy, lg);
      chk("rs1_busy", rs1_b, busy_m[rs1]);
      chk("rs2_busy", rs2_b, busy_m[rs2]);
      chk("we3", we3, we_m);
      chk("sb_err", sb_err, err_m);
      if (we_m) begin
         chk("a3", a3, a_m);
         chk("wd3", wd3, wd_m);
      end
      if (!rst_n) begin
         foreach (busy_m[i]) busy_m[i] = 1'b0;
         we_m = 1'b0; err_m = 1'b0; lsu_next_m = 1'b0; a_m = '0; wd_m = '0;
      end else begin
         grd = lg ? lsu_rd : alu_rd;
         gwd = lg ? lsu_wd : alu_wd;
         if ((ag || lg) && grd != 0 && !busy_m[grd]) err_m = 1'b1;
         if (we_m) busy_m[a_m] = 1'b0;
         if (acc && iss_rd != 0) busy_m[iss_rd] = 1'b1;
         we_m = (ag || lg) && grd != 0;
         if (ag || lg) begin
            a_m  = grd;
            wd_m = gwd;
         end
         if (both) lsu_next_m = !lsu_next_m;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] first_rd, second_rd;
      rst_n = 1'b0; iss_v = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
      alu_v = 1'b0; alu_rd = '0; alu_wd = '0;
      lsu_v = 1'b0; lsu_rd = '0; lsu_wd = '0;
      @(posedge clk);
      #1;
      step();
      rst_n = 1'b1;
      rs1 = 5'd5;
      step();
      chk("idle_we3", we3, 1'b0);
      chk("idle_rs1_busy", rs1_b, 1'b0);

      // Reserve x5, write it three cycles later.
      iss_v = 1'b1; iss_rd = 5'd5;
      step();
      iss_v = 1'b0;
      chk("x5_busy_after_issue", rs1_b, 1'b1);
      step();
      step();
      alu_v = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
      step();
      alu_v = 1'b0;
      chk("x5_we3", we3, 1'b1);
      chk("x5_a3", a3, 5'd5);
      chk("x5_wd3", wd3, 32'hDEADBEEF);
      chk("x5_busy_during_write", rs1_b, 1'b1);
      step();
      chk("x5_busy_cleared", rs1_b, 1'b0);
      chk("x5_we3_single", we3, 1'b0);

      // Contested write-back of x3 (ALU) and x4 (LSU).
      iss_v = 1'b1; iss_rd = 5'd3;
      step();
      iss_rd = 5'd4;
      step();
      iss_v = 1'b0;
      alu_v = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33;
      lsu_v = 1'b1; lsu_rd = 5'd4; lsu_wd = 32'h44;
`ifdef REGFILE_WB_RR_EN
      first_rd = 5'd3; second_rd = 5'd4;
`else
      first_rd = 5'd4; second_rd = 5'd3;
`endif
      step();
      if (first_rd == 5'd3) alu_v = 1'b0; else lsu_v = 1'b0;
      chk("contest_first_we3", we3, 1'b1);
      chk("contest_first_a3", a3, first_rd);
      step();
      alu_v = 1'b0; lsu_v = 1'b0;
      chk("contest_second_we3", we3, 1'b1);
      chk("contest_second_a3", a3, second_rd);
      step();

      // Issue to x7 stalls while x7 is pending.
      iss_v = 1'b1; iss_rd = 5'd7;
      step();
      alu_v = 1'b1; alu_rd = 5'd7; alu_wd = 32'h77;
      chk("x7_stall", iss_rdy, 1'b0);
      step();
      alu_v = 1'b0;
      chk("x7_stall_we3", iss_rdy, 1'b0);
      step();
      chk("x7_ready_after_write", iss_rdy, 1'b1);
      step();
      iss_v = 1'b0;

      // x0 write is dropped silently; unreserved x9 raises the sticky error.
      alu_v = 1'b1; alu_rd = 5'd0; alu_wd = 32'h1;
      step();
      chk("x0_we3", we3, 1'b0);
      chk("x0_sb_err", sb_err, 1'b0);
      alu_rd = 5'd9; alu_wd = 32'h99;
      step();
      alu_v = 1'b0;
      chk("x9_sb_err", sb_err, 1'b1);
      step();
      chk("x9_sb_err_sticky", sb_err, 1'b1);

      // Reset in the cycle after a grant.
      iss_v = 1'b1; iss_rd = 5'd10;
      step();
      iss_v = 1'b0;
      alu_v = 1'b1; alu_rd = 5'd10; alu_wd = 32'hA0;
      step();
      alu_v = 1'b0;
      rst_n = 1'b0;
      step();
      rs1 = 5'd10; rs2 = 5'd7;
      #1;
      chk("rst_we3", we3, 1'b0);
      chk("rst_sb_err", sb_err, 1'b0);
      chk("rst_x10_busy", rs1_b, 1'b0);
      chk("rst_x7_busy", rs2_b, 1'b0);
      rst_n = 1'b1;
      step();

      // Random traffic; a requester holds its request until granted.
      for (int n = 0; n < 3000; n++) begin
         if (ag) alu_v = 1'b0;
         if (lg) lsu_v = 1'b0;
         if (!alu_v && $urandom_range(0, 2) != 0) begin
            alu_v = 1'b1; alu_rd = 5'($urandom_range(0, 7)); alu_wd = $urandom;
         end
         if (!lsu_v && $urandom_range(0, 2) != 0) begin
            lsu_v = 1'b1; lsu_rd = 5'($urandom_range(0, 7)); lsu_wd = $urandom;
         end
         iss_v  = 1'($urandom_range(0, 1));
         iss_rd = 5'($urandom_range(0, 7));
         rs1    = 5'($urandom_range(0, 7));
         rs2    = 5'($urandom_range(0, 7));
         rst_n  = ($urandom_range(0, 80) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
